// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shares one 32-bit ALU between two valid/ready requesters, with a tagged registered response
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake for requester N (0 or 1)
//   reqN_rs, reqN_rt           operands
//   reqN_ctrl, reqN_shamt      ALU control code and shift amount
//   resp_valid / resp_ready    response handshake
//   resp_id                    requester that owns the response
//   resp_result                registered ALU result
//   resp_overflow              registered signed overflow (add/sub), only when ALU_ARB_OVF_EN is defined
//   busy                       high whenever not IDLE
// Build option: define ALU_ARB_OVF_EN to keep the overflow register; otherwise resp_overflow is tied to 0.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_rs,
    input  logic [DATA_W-1:0] req0_rt,
    input  logic [4:0]        req0_ctrl,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_rs,
    input  logic [DATA_W-1:0] req1_rt,
    input  logic [4:0]        req1_ctrl,
    input  logic [4:0]        req1_shamt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_overflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic last, idle, hs0, hs1;
    logic [DATA_W-1:0] op_rs, op_rt, alu_out, sum, diff;
    logic [4:0] op_ctrl, op_shamt;
    assign idle = state == IDLE;
    // a requester is held off only when the other one is valid and was not served last
    assign req0_ready = idle && !(req1_valid && !last);
    assign req1_ready = idle && !(req0_valid && last);
    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;
    assign busy = !idle;
    assign resp_valid = state == RESP;
    assign sum = op_rs + op_rt;
    assign diff = op_rs - op_rt;
    always_comb begin
        state_nx = idle ? ((hs0 || hs1) ? EXEC : IDLE) : (state == EXEC) ? RESP : (resp_ready ? IDLE : RESP);
    end
    always_comb begin
        alu_out = '0;
        case (op_ctrl)
            5'b00000: alu_out = op_rt << op_shamt;
            5'b00001: alu_out = op_rt >> op_shamt;
            5'b00010: alu_out = $signed(op_rt) >>> op_shamt;
            5'b00011: alu_out = op_rt << op_rs[4:0];
            5'b00100: alu_out = op_rt >> op_rs[4:0];
            5'b00101: alu_out = $signed(op_rt) >>> op_rs[4:0];
            5'b00110, 5'b00111: alu_out = sum;
            5'b01000, 5'b01001: alu_out = diff;
            5'b01010: alu_out = op_rs & op_rt;
            5'b01011: alu_out = op_rs | op_rt;
            5'b01100: alu_out = op_rs ^ op_rt;
            5'b01101: alu_out = ~(op_rs | op_rt);
            5'b01110: alu_out = {{(DATA_W-1){1'b0}}, $signed(op_rs) < $signed(op_rt)};
            5'b01111: alu_out = {{(DATA_W-1){1'b0}}, op_rs < op_rt};
            5'b10000: alu_out = op_rt << 16;
            default:  alu_out = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            resp_id     <= 1'b0;
            resp_result <= '0;
            op_rs       <= '0;
            op_rt       <= '0;
            op_ctrl     <= '0;
            op_shamt    <= '0;
        end else begin
            state <= state_nx;
            if (hs0 || hs1) begin
                last     <= hs1;
                resp_id  <= hs1;
                op_rs    <= hs1 ? req1_rs : req0_rs;
                op_rt    <= hs1 ? req1_rt : req0_rt;
                op_ctrl  <= hs1 ? req1_ctrl : req0_ctrl;
                op_shamt <= hs1 ? req1_shamt : req0_shamt;
            end
            if (state == EXEC)
                resp_result <= alu_out;
        end
    end
`ifdef ALU_ARB_OVF_EN
    logic alu_ovf, ovf_q;
    assign alu_ovf = (op_ctrl == 5'b00110) ? (op_rs[DATA_W-1] == op_rt[DATA_W-1] && sum[DATA_W-1] != op_rs[DATA_W-1]) :
                     (op_ctrl == 5'b01000) ? (op_rs[DATA_W-1] != op_rt[DATA_W-1] && diff[DATA_W-1] != op_rs[DATA_W-1]) : 1'b0;
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state == EXEC)
            ovf_q <= alu_ovf;
    end
    assign resp_overflow = ovf_q;
`else
    assign resp_overflow = 1'b0;
`endif
endmodule
